// File: rtl/regfile_write_port_arbiter_if.sv
// Write-port bundle: WB source, multi-cycle source, register file
// write stream and hazard query/status signals.
interface regfile_write_port_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_reg_write;
    logic [4:0]    wb_write_reg;
    logic [31:0]   wb_write_data;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_write_reg;
    logic [31:0]   mc_write_data;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic [4:0]    query_reg1;
    logic [4:0]    query_reg2;
    logic          pending1;
    logic          pending2;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  wb_reg_write, wb_write_reg, wb_write_data,
        input  mc_valid, mc_write_reg, mc_write_data,
        input  query_reg1, query_reg2,
        output mc_ready, reg_write, write_reg, write_data,
        output pending1, pending2, stall_req, fifo_count
    );

    modport master (
        output wb_reg_write, wb_write_reg, wb_write_data,
        output mc_valid, mc_write_reg, mc_write_data,
        output query_reg1, query_reg2,
        input  mc_ready, reg_write, write_reg, write_data,
        input  pending1, pending2, stall_req, fifo_count
    );
endinterface

// File: rtl/regfile_write_port_arbiter.sv
// Single register-file write port shared by the WB stage (priority)
// and a FIFO-buffered multi-cycle unit, with pending-write tracking.
module regfile_write_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic clk,
    input logic rst,
    regfile_write_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_reg  [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic          r_reg_write;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_write_data;

    logic w_wb_req;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_starve_inc;
    logic w_hit1;
    logic w_hit2;

    assign w_wb_req     = bus.wb_reg_write && (bus.wb_write_reg != 5'd0);
    assign w_empty      = (r_count == '0);
    assign w_ready      = !rst && (r_count < CW'(DEPTH));
    // r0 results complete the handshake but are never queued
    assign w_push       = bus.mc_valid && w_ready && (bus.mc_write_reg != 5'd0);
    assign w_pop        = !w_wb_req && !w_empty;
    assign w_starve_inc = w_wb_req && !w_empty;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                if (r_mem_reg[r_rd_ptr + AW'(i)] == bus.query_reg1) w_hit1 = 1'b1;
                if (r_mem_reg[r_rd_ptr + AW'(i)] == bus.query_reg2) w_hit2 = 1'b1;
            end
        end
        if (r_reg_write && r_write_reg == bus.query_reg1) w_hit1 = 1'b1;
        if (r_reg_write && r_write_reg == bus.query_reg2) w_hit2 = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_stall      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
        end else begin
            if (w_push) begin
                r_mem_reg[r_wr_ptr]  <= bus.mc_write_reg;
                r_mem_data[r_wr_ptr] <= bus.mc_write_data;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (w_wb_req) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= bus.wb_write_reg;
                r_write_data <= bus.wb_write_data;
            end else if (w_pop) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= r_mem_reg[r_rd_ptr];
                r_write_data <= r_mem_data[r_rd_ptr];
            end else begin
                r_reg_write  <= 1'b0;
            end

            // one-cycle bubble request once the FIFO has lost STARVE_LIMIT times
            if (w_starve_inc && r_starve == SW'(STARVE_LIMIT - 1)) begin
                r_starve <= '0;
                r_stall  <= 1'b1;
            end else if (w_starve_inc) begin
                r_starve <= r_starve + 1'b1;
                r_stall  <= 1'b0;
            end else begin
                r_starve <= '0;
                r_stall  <= 1'b0;
            end
        end
    end

    assign bus.mc_ready   = w_ready;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.pending1   = (bus.query_reg1 != 5'd0) && w_hit1;
    assign bus.pending2   = (bus.query_reg2 != 5'd0) && w_hit2;
    assign bus.stall_req  = r_stall;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_write_port_arbiter.sv
// Directed bench for regfile_write_port_arbiter: queue-based reference
// model checked every cycle plus literal expectations per scenario.
module tb_regfile_write_port_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_write_port_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
    ent_t        q[$];
    logic        m_rw = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    logic        m_stall = 1'b0;
    int          m_starve = 0;

    function automatic logic pend(logic [4:0] qr);
        if (qr == 5'd0) return 1'b0;
        if (m_rw && m_wr == qr) return 1'b1;
        foreach (q[i]) if (q[i].r == qr) return 1'b1;
        return 1'b0;
    endfunction

    // reference model: applies the arbitration rules to a plain queue
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rw = 0; m_wr = 0; m_wd = 0; m_stall = 0; m_starve = 0;
        end else begin
            automatic bit can_push = q.size() < DEPTH;
            automatic bit wb = bus.wb_reg_write && bus.wb_write_reg != 0;
            if (wb) begin
                m_rw = 1; m_wr = bus.wb_write_reg; m_wd = bus.wb_write_data;
                if (q.size() != 0) begin
                    m_starve++;
                    m_stall = (m_starve == LIMIT);
                    if (m_stall) m_starve = 0;
                end else begin
                    m_starve = 0; m_stall = 0;
                end
            end else if (q.size() != 0) begin
                automatic ent_t e = q.pop_front();
                m_rw = 1; m_wr = e.r; m_wd = e.d;
                m_starve = 0; m_stall = 0;
            end else begin
                m_rw = 0; m_starve = 0; m_stall = 0;
            end
            if (bus.mc_valid && can_push && bus.mc_write_reg != 0)
                q.push_back('{bus.mc_write_reg, bus.mc_write_data});
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("cmp reg_write", 32'(bus.reg_write), 32'(m_rw));
            check("cmp write_reg", 32'(bus.write_reg), 32'(m_wr));
            check("cmp write_data", bus.write_data, m_wd);
            check("cmp stall_req", 32'(bus.stall_req), 32'(m_stall));
            check("cmp fifo_count", 32'(bus.fifo_count), 32'(q.size()));
            check("cmp mc_ready", 32'(bus.mc_ready), 32'(!rst && q.size() < DEPTH));
            check("cmp pending1", 32'(bus.pending1), 32'(pend(bus.query_reg1)));
            check("cmp pending2", 32'(bus.pending2), 32'(pend(bus.query_reg2)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wb(logic v, logic [4:0] r, logic [31:0] d);
        bus.wb_reg_write = v; bus.wb_write_reg = r; bus.wb_write_data = d;
    endtask

    task automatic mc(logic v, logic [4:0] r, logic [31:0] d);
        bus.mc_valid = v; bus.mc_write_reg = r; bus.mc_write_data = d;
    endtask

    initial begin
        wb(0, 0, 0);
        mc(0, 0, 0);
        bus.query_reg1 = 0;
        bus.query_reg2 = 0;
        step();
        cmp_en = 1'b1;
        step();
        check("rst reg_write", 32'(bus.reg_write), 0);
        check("rst fifo_count", 32'(bus.fifo_count), 0);
        check("rst mc_ready", 32'(bus.mc_ready), 0);
        check("rst write_data", bus.write_data, 0);
        rst = 1'b0;
        #1;
        check("post-rst mc_ready", 32'(bus.mc_ready), 1);

        // WB write latency
        wb(1, 5, 32'hDEADBEEF);
        step();
        check("wb reg_write", 32'(bus.reg_write), 1);
        check("wb write_reg", 32'(bus.write_reg), 5);
        check("wb write_data", bus.write_data, 32'hDEADBEEF);
        wb(0, 0, 0);
        step();
        check("wb idle reg_write", 32'(bus.reg_write), 0);
        check("wb idle hold reg", 32'(bus.write_reg), 5);

        // multi-cycle write latency and pending
        mc(1, 9, 32'h12345678);
        bus.query_reg1 = 9;
        step();
        check("mc E0 count", 32'(bus.fifo_count), 1);
        check("mc E0 pending", 32'(bus.pending1), 1);
        check("mc E0 reg_write", 32'(bus.reg_write), 0);
        mc(0, 0, 0);
        step();
        check("mc E1 reg_write", 32'(bus.reg_write), 1);
        check("mc E1 write_reg", 32'(bus.write_reg), 9);
        check("mc E1 data", bus.write_data, 32'h12345678);
        check("mc E1 pending", 32'(bus.pending1), 1);
        step();
        check("mc E2 pending", 32'(bus.pending1), 0);

        // starvation: WB every cycle while the unit keeps pushing
        bus.query_reg2 = 13;
        for (int k = 1; k <= 9; k++) begin
            wb(1, 1, 32'(k));
            mc(1, 5'(9 + k), 32'hA0 + 32'(k));
            step();
            if (k == 4) begin
                check("full count", 32'(bus.fifo_count), 4);
                check("full mc_ready", 32'(bus.mc_ready), 0);
                check("full pending r13", 32'(bus.pending2), 1);
            end
            if (k == 8) check("starve no stall yet", 32'(bus.stall_req), 0);
        end
        check("starve stall_req", 32'(bus.stall_req), 1);
        check("starve count", 32'(bus.fifo_count), 4);
        wb(0, 0, 0);
        step();
        check("bubble pop count", 32'(bus.fifo_count), 3);
        check("bubble write_reg", 32'(bus.write_reg), 10);
        check("bubble data", bus.write_data, 32'hA1);
        check("bubble mc_ready", 32'(bus.mc_ready), 1);
        check("bubble stall off", 32'(bus.stall_req), 0);
        mc(0, 0, 0);
        repeat (3) step();
        check("drain last reg", 32'(bus.write_reg), 13);
        check("drain count", 32'(bus.fifo_count), 0);
        step();
        check("drain idle", 32'(bus.reg_write), 0);

        // WB to r0 yields to the FIFO and is never written
        mc(1, 3, 32'h33);
        step();
        mc(0, 0, 0);
        wb(1, 0, 32'hFFFF_FFFF);
        step();
        check("r0 wb pops r3", 32'(bus.write_reg), 3);
        check("r0 wb pop data", bus.write_data, 32'h33);
        check("r0 wb count", 32'(bus.fifo_count), 0);
        step();
        check("r0 wb no write", 32'(bus.reg_write), 0);
        wb(0, 0, 0);

        // mc write to r0 completes without enqueueing
        mc(1, 0, 32'h55);
        #1;
        check("r0 mc ready", 32'(bus.mc_ready), 1);
        step();
        check("r0 mc count", 32'(bus.fifo_count), 0);
        check("r0 mc no write", 32'(bus.reg_write), 0);

        // reset discards queued entries
        wb(1, 1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            mc(1, 5'(20 + k), 32'(k));
            step();
        end
        check("pre-rst count", 32'(bus.fifo_count), 3);
        bus.query_reg1 = 21;
        rst = 1'b1;
        wb(0, 0, 0);
        step();
        check("mid-rst count", 32'(bus.fifo_count), 0);
        check("mid-rst reg_write", 32'(bus.reg_write), 0);
        check("mid-rst pending", 32'(bus.pending1), 0);
        check("mid-rst mc_ready", 32'(bus.mc_ready), 0);
        rst = 1'b0;
        mc(0, 0, 0);
        step();
        check("after-rst mc_ready", 32'(bus.mc_ready), 1);
        check("after-rst count", 32'(bus.fifo_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_port_arbiter.md
Name: regfile_write_port_arbiter

Overview:
- Writer side of the register file's single write port.
- Merges two write sources into one registered write stream (reg_write / write_reg / write_data) that drives the register file:
  - the pipeline WB stage: fixed priority, never back-pressured;
  - a multi-cycle execution unit (mul/div): valid/ready handshake, buffered in a small FIFO.
- Reports pending destinations so the hazard unit can stall readers of not-yet-written registers.

Parameters:
- DEPTH, 4, FIFO entries for multi-cycle results (power of two, >=2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose to WB before stall_req is raised.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_reg_write  in  1  WB stage write enable.
- wb_write_reg  in  5  WB destination register.
- wb_write_data  in  32  WB data.
- mc_valid  in  1  multi-cycle unit result valid.
- mc_ready  out  1  FIFO can accept a result.
- mc_write_reg  in  5  multi-cycle destination register.
- mc_write_data  in  32  multi-cycle result.
- reg_write  out  1  register file write enable (registered).
- write_reg  out  5  register file write address (registered).
- write_data  out  32  register file write data (registered).
- query_reg1  in  5  hazard query, source 1.
- query_reg2  in  5  hazard query, source 2.
- pending1  out  1  query_reg1 has an outstanding write.
- pending2  out  1  query_reg2 has an outstanding write.
- stall_req  out  1  request one WB bubble to drain the FIFO.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - reg_write=0, write_reg=0, write_data=0, stall_req=0, starvation counter=0.
  - FIFO empty (rd/wr pointers 0), fifo_count=0.
  - mc_ready=0 while rst is high; no pushes are taken.
- Reset mid-operation discards all buffered entries. Dropped writes are the upstream's responsibility.
- Accept (push):
  - A push occurs when mc_valid && mc_ready at a posedge.
  - mc_ready = !rst && (fifo_count < DEPTH). It depends on occupancy only, not on a same-cycle pop, so a full FIFO never pushes even while popping.
  - mc_write_reg=0: the handshake completes but nothing is enqueued.
- Output selection at each posedge, in priority order:
  - 1) wb_reg_write && wb_write_reg!=0: output register loads the WB write.
  - 2) else if FIFO non-empty: pop the head into the output register.
  - 3) else reg_write<=0; write_reg and write_data hold their previous values.
- WB to r0 is dropped: treated as no WB request, so the FIFO may pop that cycle.
- Latency:
  - WB write: reg_write is high in the cycle after the WB-valid edge.
  - Multi-cycle write: minimum 2 cycles. Push at edge E0, pop at E1, reg_write high after E1.
- Simultaneous push and pop: both happen; fifo_count is unchanged. A pushed entry is never popped in the same edge.
- Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- pending1/2 (combinational): 1 iff query!=0 and it matches either
  - write_reg of any valid FIFO entry, or
  - write_reg while reg_write=1.
- Ordering: no reordering is performed. The hazard unit must use pending to prevent WB writes to a register that still has a queued multi-cycle write (WAW).
- Starvation:
  - Counter increments on each edge where the FIFO is non-empty and WB wins.
  - Counter clears on any pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_req is 1 for exactly the next cycle and the counter clears.
  - The pipeline must hold wb_reg_write=0 during that cycle. If WB still arrives, WB keeps priority.

Test Plan:
- Reset, then WB write r5=0xDEADBEEF -> reg_write=1, write_reg=5, write_data=0xDEADBEEF one cycle later; next idle cycle reg_write=0.
- Idle WB, mc push r9=0x12345678 -> fifo_count 1 after E0; reg_write=1/write_reg=9 after E1; pending(9)=1 from E0 until the cycle after reg_write drops.
- Continuous mc_valid with WB writing every cycle, DEPTH=4 -> fifo_count reaches 4 and mc_ready=0; stall_req pulses after 8 losing cycles; a bubble pops one entry and mc_ready returns to 1.
- Full FIFO with a pop and mc_valid=1 in the same cycle -> no push; fifo_count goes 4->3.
- WB to r0 while FIFO holds r3 -> FIFO pops r3; no write to r0 is ever issued. mc write to r0 -> handshake completes, fifo_count unchanged.
- rst asserted with 3 entries queued -> fifo_count=0, reg_write=0, pending=0, mc_ready=0 during reset and 1 after.
